gb_mixer: RTL and testbench

- Downstream stage of every APU channel, including the pulse channels. Consumes the four 4-bit channel levels and their enable flags.
- Applies NR51 panning and NR50 master volume, and produces registered left/right samples at a fixed sample rate with a one-cycle valid strobe.
- Drives a first-order sigma-delta 1-bit DAC bitstream per side for direct pin output.

---
 rtl/gb_mixer.sv | 146 ++++++++++++++
 tb/tb_gb_mixer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gb_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : gb_mixer
//  Description : APU output mixer. Gates and pans the four channel levels,
//                applies master volume, and emits registered left/right
//                samples at a fixed rate with a one-cycle valid strobe. A
//                first-order sigma-delta modulator per side produces a 1-bit
//                DAC bitstream for direct pin output.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_mixer #(
  parameter int SAMPLE_DIV = 95
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_enable,
  input  logic [3:0] ch1_level,
  input  logic [3:0] ch2_level,
  input  logic [3:0] ch3_level,
  input  logic [3:0] ch4_level,
  input  logic [3:0] ch_enable,
  input  logic [7:0] nr51,
  input  logic [7:0] nr50,
  output logic [8:0] sample_left,
  output logic [8:0] sample_right,
  output logic       sample_valid,
  output logic       dac_left,
  output logic       dac_right
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  // Sample-rate divider
  logic [15:0] div_q, div_d;
  logic        w_tick;

  // Stage 1: panned sums, plus a flag marking that stage 1 just loaded
  logic [5:0]  sum_l_q, sum_l_d;
  logic [5:0]  sum_r_q, sum_r_d;
  logic        s1_valid_q, s1_valid_d;

  // Stage 2: volume-scaled samples and their strobe
  logic [8:0]  sample_l_q, sample_l_d;
  logic [8:0]  sample_r_q, sample_r_d;
  logic        valid_q, valid_d;

  // Sigma-delta accumulators; bit 9 is the DAC output bit
  logic [9:0]  acc_l_q, acc_l_d;
  logic [9:0]  acc_r_q, acc_r_d;

  // Gated channel levels and helper terms
  logic [5:0]  w_g1, w_g2, w_g3, w_g4;
  logic [5:0]  w_sum_l, w_sum_r;
  logic [3:0]  w_vol_l, w_vol_r;
  logic [8:0]  w_prod_l, w_prod_r;
  logic        w_unused_vin;

  // VIN bits of NR50 have no effect on the mix
  assign w_unused_vin = nr50[7] ^ nr50[3];

  assign w_tick = (div_q == DIV_LAST);

  // Channel gating, panning sums and volume products
  always_comb begin
    w_g1 = ch_enable[0] ? {2'b00, ch1_level} : 6'd0;
    w_g2 = ch_enable[1] ? {2'b00, ch2_level} : 6'd0;
    w_g3 = ch_enable[2] ? {2'b00, ch3_level} : 6'd0;
    w_g4 = ch_enable[3] ? {2'b00, ch4_level} : 6'd0;

    w_sum_l = (nr51[4] ? w_g1 : 6'd0) + (nr51[5] ? w_g2 : 6'd0)
            + (nr51[6] ? w_g3 : 6'd0) + (nr51[7] ? w_g4 : 6'd0);
    w_sum_r = (nr51[0] ? w_g1 : 6'd0) + (nr51[1] ? w_g2 : 6'd0)
            + (nr51[2] ? w_g3 : 6'd0) + (nr51[3] ? w_g4 : 6'd0);

    // Volume codes 0..7 map to multipliers 1..8
    w_vol_l = {1'b0, nr50[6:4]} + 4'd1;
    w_vol_r = {1'b0, nr50[2:0]} + 4'd1;

    // 60 x 8 = 480 fits in 9 bits, so no clipping is needed
    w_prod_l = {3'b000, sum_l_q} * {5'b00000, w_vol_l};
    w_prod_r = {3'b000, sum_r_q} * {5'b00000, w_vol_r};
  end

  // Next-state logic for divider, both pipeline stages and the DAC
  always_comb begin
    div_d      = w_tick ? 16'd0 : div_q + 16'd1;

    sum_l_d    = sum_l_q;
    sum_r_d    = sum_r_q;
    s1_valid_d = w_tick;
    if (w_tick) begin
      sum_l_d = apu_enable ? w_sum_l : 6'd0;
      sum_r_d = apu_enable ? w_sum_r : 6'd0;
    end

    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d    = s1_valid_q;
    if (s1_valid_q) begin
      sample_l_d = w_prod_l;
      sample_r_d = w_prod_r;
    end

    // Carry out of the 9-bit sum lands in bit 9 and is the output bit;
    // it is dropped on the following update.
    acc_l_d = {1'b0, acc_l_q[8:0]} + {1'b0, sample_l_q};
    acc_r_d = {1'b0, acc_r_q[8:0]} + {1'b0, sample_r_q};
    if (!apu_enable) begin
      acc_l_d = 10'd0;
      acc_r_d = 10'd0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= 16'd0;
      sum_l_q    <= 6'd0;
      sum_r_q    <= 6'd0;
      s1_valid_q <= 1'b0;
      sample_l_q <= 9'd0;
      sample_r_q <= 9'd0;
      valid_q    <= 1'b0;
      acc_l_q    <= 10'd0;
      acc_r_q    <= 10'd0;
    end else begin
      div_q      <= div_d;
      sum_l_q    <= sum_l_d;
      sum_r_q    <= sum_r_d;
      s1_valid_q <= s1_valid_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
    end
  end

  assign sample_left  = sample_l_q;
  assign sample_right = sample_r_q;
  assign sample_valid = valid_q;
  assign dac_left     = acc_l_q[9];
  assign dac_right    = acc_r_q[9];

endmodule
`default_nettype wire

// File: tb/tb_gb_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_mixer
//  Description : Directed self-checking bench for gb_mixer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_mixer;

  logic       clk = 1'b0;
  logic       reset;
  logic       apu_enable;
  logic [3:0] ch1_level, ch2_level, ch3_level, ch4_level;
  logic [3:0] ch_enable;
  logic [7:0] nr51, nr50;
  logic [8:0] sample_left, sample_right;
  logic       sample_valid;
  logic       dac_left, dac_right;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gb_mixer #(.SAMPLE_DIV(95)) dut (
    .clk          (clk),
    .reset        (reset),
    .apu_enable   (apu_enable),
    .ch1_level    (ch1_level),
    .ch2_level    (ch2_level),
    .ch3_level    (ch3_level),
    .ch4_level    (ch4_level),
    .ch_enable    (ch_enable),
    .nr51         (nr51),
    .nr50         (nr50),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .dac_left     (dac_left),
    .dac_right    (dac_right)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until sample_valid is seen (bounded); returns edges consumed
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!sample_valid && n < 300);
    check(tag, {31'd0, sample_valid}, 32'd1);
  endtask

  task automatic set_inputs(input logic [3:0] l1, input logic [3:0] l2,
                            input logic [3:0] l3, input logic [3:0] l4,
                            input logic [3:0] en, input logic [7:0] p,
                            input logic [7:0] v);
    ch1_level = l1; ch2_level = l2; ch3_level = l3; ch4_level = l4;
    ch_enable = en; nr51 = p; nr50 = v;
  endtask

  initial begin
    int n;
    int cnt_l, cnt_r, strobes;
    logic [8:0] or_l, or_r;

    reset      = 1'b1;
    apu_enable = 1'b1;
    set_inputs(4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 8'hFF, 8'h77);
    step(3);
    check("reset_left",  32'(sample_left),  32'd0);
    check("reset_right", 32'(sample_right), 32'd0);
    check("reset_valid", 32'(sample_valid), 32'd0);
    check("reset_dacl",  32'(dac_left),     32'd0);
    check("reset_dacr",  32'(dac_right),    32'd0);

    // First strobe latency and period
    reset = 1'b0;
    wait_valid("first_strobe", n);
    check("first_strobe_latency", n, 96);
    check("full_left",  32'(sample_left),  32'd480);
    check("full_right", 32'(sample_right), 32'd480);
    wait_valid("second_strobe", n);
    check("strobe_period", n, 95);
    step(1);
    check("valid_one_cycle", 32'(sample_valid), 32'd0);

    // DAC density at sample 480 over 512 cycles
    cnt_l = 0; cnt_r = 0;
    for (int i = 0; i < 512; i++) begin
      step(1);
      if (dac_left)  cnt_l++;
      if (dac_right) cnt_r++;
    end
    check("dacl_density_in_480pm1", {31'd0, (cnt_l >= 479 && cnt_l <= 481)}, 32'd1);
    check("dacr_density_in_480pm1", {31'd0, (cnt_r >= 479 && cnt_r <= 481)}, 32'd1);

    // Pan/volume pattern: left ch1 x4, right ch2 x1
    wait_valid("drain_strobe", n);
    set_inputs(4'd10, 4'd5, 4'd0, 4'd0, 4'h3, 8'h12, 8'h30);
    wait_valid("pan_strobe", n);
    check("pan_left",  32'(sample_left),  32'd40);
    check("pan_right", 32'(sample_right), 32'd5);

    // Channel 1 disabled at full level; VIN bit set; left x6, right x3
    set_inputs(4'd15, 4'd3, 4'd2, 4'd1, 4'hE, 8'hFF, 8'hD2);
    wait_valid("mask_strobe", n);
    check("mask_left",  32'(sample_left),  32'd36);
    check("mask_right", 32'(sample_right), 32'd18);

    // Capture timing: change inputs in the cycle after the tick
    set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'hF, 8'hFF, 8'h00);
    wait_valid("capture_setup_strobe", n);
    check("capture_setup_left",  32'(sample_left),  32'd10);
    check("capture_setup_right", 32'(sample_right), 32'd10);
    step(94);
    set_inputs(4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 8'hFF, 8'h21);
    step(1);
    check("capture_valid", 32'(sample_valid), 32'd1);
    check("capture_left",  32'(sample_left),  32'd30);
    check("capture_right", 32'(sample_right), 32'd20);
    wait_valid("capture_next_strobe", n);
    check("capture_next_period", n, 95);
    check("capture_next_left",  32'(sample_left),  32'd180);
    check("capture_next_right", 32'(sample_right), 32'd120);

    // APU disabled: strobes continue with zero samples, DAC silent
    apu_enable = 1'b0;
    step(1);
    cnt_l = 0; cnt_r = 0; strobes = 0; or_l = '0; or_r = '0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (dac_left)  cnt_l++;
      if (dac_right) cnt_r++;
      if (sample_valid) begin
        strobes++;
        or_l |= sample_left;
        or_r |= sample_right;
      end
    end
    check("off_dacl_highs", cnt_l, 0);
    check("off_dacr_highs", cnt_r, 0);
    check("off_strobes_ge10", {31'd0, (strobes >= 10)}, 32'd1);
    check("off_left",  32'(or_l), 32'd0);
    check("off_right", 32'(or_r), 32'd0);

    // Reset while stage 2 is pending
    apu_enable = 1'b1;
    set_inputs(4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 8'hFF, 8'h77);
    wait_valid("rst_drain_strobe", n);
    wait_valid("rst_setup_strobe", n);
    check("rst_setup_left", 32'(sample_left), 32'd480);
    step(94);
    reset = 1'b1;
    step(1);
    check("rst_mid_valid", 32'(sample_valid), 32'd0);
    check("rst_mid_left",  32'(sample_left),  32'd0);
    check("rst_mid_right", 32'(sample_right), 32'd0);
    check("rst_mid_dacl",  32'(dac_left),     32'd0);
    check("rst_mid_dacr",  32'(dac_right),    32'd0);
    reset = 1'b0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (sample_valid) strobes++;
    end
    check("rst_no_stale_strobe", strobes, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
